// File: rtl/izh_pkg.sv
// izh_pkg: shared FSM type, fixed-point constants and saturation helper
// for the time-multiplexed Izhikevich neuron array.
package izh_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } izh_state_e;

  localparam int IZH_FRAC_DEF   = 7;
  localparam int IZH_K04_DEF    = 5;
  localparam int IZH_K5         = 5;
  localparam int IZH_K140       = 140;
  localparam int IZH_C_DEF      = -8320;
  localparam int IZH_D_DEF      = 1024;
  localparam int IZH_THRESH_DEF = 3840;

  // 0.04 in Q.frac, rounded; the quadratic term pairs it with >>> 2*frac
  function automatic int k04(input int frac);
    if (frac == IZH_FRAC_DEF) return IZH_K04_DEF;
    return (4 * (1 << frac) + 50) / 100;
  endfunction

  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] x,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/izh_neuron_array_if.sv
// izh_neuron_array_if: step/spike handshake and state readback bus
// between the current generator and the neuron array.
interface izh_neuron_array_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                step_i;
  logic [N*W-1:0]      currents_i;
  logic                busy_o;
  logic [N-1:0]        spikes_o;
  logic                spike_valid_o;
  logic                overrun_o;
  logic [IW-1:0]       rd_idx_i;
  logic signed [W-1:0] rd_v_o;
  logic signed [W-1:0] rd_u_o;

  modport master (
    output step_i, currents_i, rd_idx_i,
    input  busy_o, spikes_o, spike_valid_o,
    input  overrun_o, rd_v_o, rd_u_o
  );

  modport slave (
    input  step_i, currents_i, rd_idx_i,
    output busy_o, spikes_o, spike_valid_o,
    output overrun_o, rd_v_o, rd_u_o
  );

endinterface

// File: rtl/izh_update_core.sv
// izh_update_core: combinational Izhikevich update for one neuron,
// Q.FRAC arithmetic at 2W+8 bits, saturated back to W bits.
module izh_update_core
  import izh_pkg::*;
#(
  parameter int W        = 16,
  parameter int FRAC     = 7,
  parameter int DT_SHIFT = 4,
  parameter int A        = 3,
  parameter int B        = 26,
  parameter int C        = IZH_C_DEF,
  parameter int D        = IZH_D_DEF,
  parameter int THRESH   = IZH_THRESH_DEF
) (
  input  logic signed [W-1:0] v_i,
  input  logic signed [W-1:0] u_i,
  input  logic signed [W-1:0] cur_i,
  output logic signed [W-1:0] v_o,
  output logic signed [W-1:0] u_o,
  output logic                spike_o
);

  localparam int XW = 2 * W + 8;
  typedef logic signed [XW-1:0] xw_t;

  localparam xw_t K04  = xw_t'(k04(FRAC));
  localparam xw_t K5   = xw_t'(IZH_K5);
  localparam xw_t K140 = xw_t'(IZH_K140) <<< FRAC;
  localparam xw_t KA   = xw_t'(A);
  localparam xw_t KB   = xw_t'(B);
  localparam logic signed [63:0] KD = 64'(D);
  localparam logic signed [63:0] KT = 64'(THRESH);

  xw_t v, u, cur, quad, dv, du, vn, un;
  logic signed [63:0] vs, us;

  always_comb begin
    v    = xw_t'(v_i);
    u    = xw_t'(u_i);
    cur  = xw_t'(cur_i);
    quad = (K04 * v * v) >>> (2 * FRAC);
    dv   = (quad + K5 * v + K140 - u + cur) >>> DT_SHIFT;
    vn   = v + dv;
    du   = (KA * (((KB * v) >>> FRAC) - u)) >>> (FRAC + DT_SHIFT);
    un   = u + du;
    vs   = sat_w(64'(vn), W);
    us   = sat_w(64'(un), W);
    spike_o = vs >= KT;
    v_o  = spike_o ? W'(C) : W'(vs);
    u_o  = spike_o ? W'(sat_w(us + KD, W)) : W'(us);
  end

endmodule

// File: rtl/izh_neuron_array.sv
// izh_neuron_array: N Izhikevich neurons sharing one update core, one
// neuron per cycle per sweep. Optional refractory: IZH_REFRACTORY_EN.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = IZH_FRAC_DEF,
  parameter int DT_SHIFT = 4,
  parameter int A        = 3,
  parameter int B        = 26,
  parameter int C        = IZH_C_DEF,
  parameter int D        = IZH_D_DEF,
  parameter int THRESH   = IZH_THRESH_DEF,
  parameter int REFRAC   = 2
) (
  input logic               clk,
  input logic               reset_n,
  izh_neuron_array_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W-1:0] V_RST = W'(C);
  localparam logic signed [W-1:0] U_RST = W'((B * C) >>> FRAC);

  izh_state_e          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic signed [W-1:0] v_q   [N];
  logic signed [W-1:0] u_q   [N];
  logic signed [W-1:0] cur_q [N];
  logic [N-1:0]        shadow_q, spikes_q;
  logic                valid_q, overrun_q;
  logic signed [W-1:0] rd_v_q, rd_u_q;
  logic signed [W-1:0] vn, un;
  logic                spk, last;

`ifdef IZH_REFRACTORY_EN
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  logic [RW-1:0] rc_q [N];
`endif

  assign last = idx_q == IW'(N - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.step_i) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (last) state_d = S_DONE;
        else      idx_d   = idx_q + IW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  izh_update_core #(
    .W(W), .FRAC(FRAC), .DT_SHIFT(DT_SHIFT),
    .A(A), .B(B), .C(C), .D(D), .THRESH(THRESH)
  ) u_core (
    .v_i    (v_q[idx_q]),
    .u_i    (u_q[idx_q]),
    .cur_i  (cur_q[idx_q]),
    .v_o    (vn),
    .u_o    (un),
    .spike_o(spk)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= V_RST;
        u_q[i]   <= U_RST;
        cur_q[i] <= '0;
`ifdef IZH_REFRACTORY_EN
        rc_q[i]  <= '0;
`endif
      end
      shadow_q  <= '0;
      spikes_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.step_i && state_q != S_IDLE) overrun_q <= 1'b1;
      if (state_q == S_IDLE && bus.step_i) begin
        for (int i = 0; i < N; i++)
          cur_q[i] <= bus.currents_i[i*W +: W];
      end
      if (state_q == S_SWEEP) begin
`ifdef IZH_REFRACTORY_EN
        // refractory neuron: clamp v, hold u, count down, no spike
        if (rc_q[idx_q] != '0) begin
          v_q[idx_q]      <= V_RST;
          rc_q[idx_q]     <= rc_q[idx_q] - RW'(1);
          shadow_q[idx_q] <= 1'b0;
        end else begin
          v_q[idx_q]      <= vn;
          u_q[idx_q]      <= un;
          shadow_q[idx_q] <= spk;
          if (spk) rc_q[idx_q] <= RW'(REFRAC);
        end
`else
        v_q[idx_q]      <= vn;
        u_q[idx_q]      <= un;
        shadow_q[idx_q] <= spk;
`endif
      end
      if (state_q == S_DONE) begin
        spikes_q <= shadow_q;
        valid_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v_q <= V_RST;
      rd_u_q <= U_RST;
    end else begin
      rd_v_q <= v_q[bus.rd_idx_i];
      rd_u_q <= u_q[bus.rd_idx_i];
    end
  end

  assign bus.busy_o        = state_q != S_IDLE;
  assign bus.spikes_o      = spikes_q;
  assign bus.spike_valid_o = valid_q;
  assign bus.overrun_o     = overrun_q;
  assign bus.rd_v_o        = rd_v_q;
  assign bus.rd_u_o        = rd_u_q;

endmodule

// File: tb/tb_izh_neuron_array.sv
// tb_izh_neuron_array: directed checks of reset, sweep timing, drive,
// overrun, reset mid-sweep and (optionally) refractory behaviour.
module tb_izh_neuron_array;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  izh_neuron_array_if #(.N(4), .W(16)) bus ();

  izh_neuron_array #(.N(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint   mv [4];
  longint   mu [4];
  longint   mc [4];
  logic [3:0] mspk;
`ifdef IZH_REFRACTORY_EN
  int       mr [4];
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // reference sweep over all four neurons with the default constants
  task automatic mstep();
    for (int k = 0; k < 4; k++) begin
      longint q, vn, un;
`ifdef IZH_REFRACTORY_EN
      if (mr[k] != 0) begin
        mv[k] = -8320;
        mr[k]--;
        mspk[k] = 1'b0;
        continue;
      end
`endif
      q  = (5 * mv[k] * mv[k]) >>> 14;
      vn = sat16(mv[k] + ((q + 5 * mv[k] + 17920 - mu[k] + mc[k]) >>> 4));
      un = sat16(mu[k] + ((3 * (((26 * mv[k]) >>> 7) - mu[k])) >>> 11));
      if (vn >= 3840) begin
        mspk[k] = 1'b1;
        mv[k]   = -8320;
        mu[k]   = sat16(un + 1024);
`ifdef IZH_REFRACTORY_EN
        mr[k]   = 2;
`endif
      end else begin
        mspk[k] = 1'b0;
        mv[k]   = vn;
        mu[k]   = un;
      end
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = -8320;
      mu[k] = -1690;
`ifdef IZH_REFRACTORY_EN
      mr[k] = 0;
`endif
    end
  endtask

  task automatic set_cur(input longint c0, c1, c2, c3);
    mc[0] = c0; mc[1] = c1; mc[2] = c2; mc[3] = c3;
    bus.currents_i = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endtask

  task automatic rd(input int k, output longint v, output longint u);
    bus.rd_idx_i = 2'(k);
    tick();
    v = longint'(bus.rd_v_o);
    u = longint'(bus.rd_u_o);
  endtask

  // returns cycles from acceptance edge to the valid strobe (bounded)
  task automatic do_step(output int cyc);
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (bus.spike_valid_o) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v, u;
    int     cyc, nv;
    logic   seen;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.step_i = 1'b0;
    bus.rd_idx_i = '0;
    set_cur(0, 0, 0, 0);
    mreset();
    tick();
    tick();

    // reset state
    chk("rst_busy",  bus.busy_o, 0);
    chk("rst_spk",   bus.spikes_o, 0);
    chk("rst_valid", bus.spike_valid_o, 0);
    chk("rst_ovr",   bus.overrun_o, 0);
    chk("rst_rdv",   bus.rd_v_o, -8320);
    chk("rst_rdu",   bus.rd_u_o, -1690);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd(k, v, u);
      chk($sformatf("rst_v%0d", k), v, -8320);
      chk($sformatf("rst_u%0d", k), u, -1690);
    end

    // single step, zero current: valid 5 cycles after acceptance
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    chk("z_busy_hi", bus.busy_o, 1);
    nv = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus.busy_o === 1'b1 && bus.spike_valid_o === 1'b0) nv++;
    end
    chk("z_busy_cycles", nv, 4);
    tick();
    chk("z_valid", bus.spike_valid_o, 1);
    chk("z_busy_lo", bus.busy_o, 0);
    chk("z_spk", bus.spikes_o, 0);
    tick();
    chk("z_valid_pulse", bus.spike_valid_o, 0);
    rd(0, v, u);
    chk("z_v0", v, -8375);
    chk("z_u0", u, -1690);
    rd(3, v, u);
    chk("z_v3", v, -8375);
    chk("z_u3", u, -1690);
    for (int k = 0; k < 4; k++) begin
      mv[k] = -8375;
      mu[k] = -1690;
    end

    // sustained drive on neuron 1 at back-to-back step rate
    set_cur(0, 32767, 0, 0);
    seen = 1'b0;
    for (int s = 0; s < 14; s++) begin
      mstep();
      do_step(cyc);
      chk($sformatf("d_lat%0d", s), cyc, 5);
      chk($sformatf("d_spk%0d", s), bus.spikes_o, mspk);
      if (bus.spikes_o[1] === 1'b1 && !seen) begin
        seen = 1'b1;
        rd(1, v, u);
        chk("d_spk_v1", v, -8320);
        chk("d_spk_u1", u, mu[1]);
      end
    end
    chk("d_seen", seen, 1);
    rd(0, v, u);
    chk("d_v0", v, mv[0]);
    chk("d_u0", u, mu[0]);

    // overrun: second request 2 edges into a sweep; current change ignored
    chk("o_pre", bus.overrun_o, 0);
    mstep();
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    bus.currents_i = {16'd0, 16'd0, 16'd0, 16'sd20000};
    tick();
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    chk("o_set", bus.overrun_o, 1);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.spike_valid_o) nv++;
      tick();
    end
    set_cur(0, 32767, 0, 0);
    chk("o_nvalid", nv, 1);
    chk("o_sticky", bus.overrun_o, 1);
    chk("o_spk", bus.spikes_o, mspk);
    for (int k = 0; k < 4; k++) begin
      rd(k, v, u);
      chk($sformatf("o_v%0d", k), v, mv[k]);
      chk($sformatf("o_u%0d", k), u, mu[k]);
    end

    // reset asserted mid-sweep
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("r_busy", bus.busy_o, 0);
    tick();
    reset_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.spike_valid_o) nv++;
      tick();
    end
    chk("r_nvalid", nv, 0);
    chk("r_ovr", bus.overrun_o, 0);
    chk("r_spk", bus.spikes_o, 0);
    for (int k = 0; k < 4; k++) begin
      rd(k, v, u);
      chk($sformatf("r_v%0d", k), v, -8320);
      chk($sformatf("r_u%0d", k), u, -1690);
    end
    mreset();

`ifdef IZH_REFRACTORY_EN
    begin
      longint u_sp;
      seen = 1'b0;
      for (int s = 0; s < 20 && !seen; s++) begin
        mstep();
        do_step(cyc);
        if (bus.spikes_o[1] === 1'b1) seen = 1'b1;
      end
      chk("rf_seen", seen, 1);
      u_sp = mu[1];
      for (int s = 0; s < 2; s++) begin
        mstep();
        do_step(cyc);
        chk($sformatf("rf_spk%0d", s), bus.spikes_o[1], 0);
        rd(1, v, u);
        chk($sformatf("rf_v%0d", s), v, -8320);
        chk($sformatf("rf_u%0d", s), u, u_sp);
      end
      mstep();
      do_step(cyc);
      rd(1, v, u);
      chk("rf_v_resume", v, mv[1]);
      chk("rf_u_resume", u, mu[1]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/izh_neuron_array.md
# izh_neuron_array

Time-multiplexed array of N Izhikevich neurons that shares one fixed-point update datapath across all neurons. Each `step_i` pulse triggers one sweep that updates every neuron once. The block then publishes a registered spike vector with a one-cycle valid strobe. It sits between the stimulus/current generator and the spike-event encoder, and supersedes the single-neuron block for multi-channel builds.

## Interface
- `N`, 4: neuron count, ≥1.
- `W`, 16: width of state words and current, in signed Q(W−FRAC).FRAC.
- `FRAC`, 7: fractional bits.
- `DT_SHIFT`, 4: integration step, dt = 2^−DT_SHIFT.
- `A`, 3: 0.02 in Q.FRAC.
- `B`, 26: 0.2 in Q.FRAC.
- `C`, −8320: reset potential, −65.
- `D`, 1024: recovery increment, 8.
- `THRESH`, 3840: spike threshold, 30.
- `REFRAC`, 2: refractory steps; used only with `IZH_REFRACTORY_EN`.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `step_i`, in, 1: single-cycle request to run one sweep.
- `currents_i`, in, N*W: per-neuron current; neuron i occupies bits [i*W +: W].
- `busy_o`, out, 1: high while a sweep is in progress.
- `spikes_o`, out, N: spike vector from the last completed sweep.
- `spike_valid_o`, out, 1: one-cycle strobe marking a new `spikes_o`.
- `overrun_o`, out, 1: sticky flag; set when `step_i` arrives while busy.
- `rd_idx_i`, in, $clog2(N) (minimum 1): neuron select for readback.
- `rd_v_o`, out, W: registered `v` of neuron `rd_idx_i`.
- `rd_u_o`, out, W: registered `u` of neuron `rd_idx_i`.

## Operation
- **State storage:** per-neuron registers `v[i]` and `u[i]`, plus a shadow spike vector.
- **FSM states:** IDLE, SWEEP, DONE.
  - IDLE, `step_i`=1: capture all of `currents_i` into a current buffer, set idx=0, go to SWEEP, raise `busy_o`.
  - SWEEP: each cycle, read neuron idx, compute its update, write it back, record its spike bit in the shadow vector. After idx=N−1, go to DONE.
  - DONE: copy the shadow vector to `spikes_o`, pulse `spike_valid_o`, drop `busy_o`, go to IDLE.
- **`step_i` while busy (SWEEP or DONE):** the request is ignored, `overrun_o` is set, and the sweep in progress is unaffected.
- **Update arithmetic:** all intermediates are signed at 2W+8 bits; every `>>>` is an arithmetic shift (floor).
  - vn = v + ((5·v·v >>> 2·FRAC) + 5·v + (140<<FRAC) − u + I) >>> DT_SHIFT
  - un = u + ((A·(((B·v) >>> FRAC) − u)) >>> (FRAC+DT_SHIFT))
  - vn and un saturate to the signed W-bit range before the threshold compare.
  - The 0.04 coefficient is the constant 5 paired with the shift 2·FRAC; this identity holds only for FRAC=7. For FRAC≠7 the coefficient constant is recomputed as round(0.04·2^FRAC) and the implementation must keep the intended 0.04 scale.
- **Spike rule:** if vn ≥ THRESH, write v ← C and u ← sat(un + D), and set the spike bit. Otherwise write v ← vn and u ← un.
- **Reset values:** every v[i]=C; every u[i]=(B·C)>>>FRAC (−1690 at defaults); `spikes_o`=0; `spike_valid_o`=0; `busy_o`=0; `overrun_o`=0; `rd_v_o`=C; `rd_u_o`=(B·C)>>>FRAC; FSM in IDLE; current buffer 0.
- **Reset mid-sweep:** all neurons return to their reset values, including neurons already updated in that sweep. No `spike_valid_o` is produced.

## Timing
- `step_i` accepted at clock edge t.
- Neuron i is written at edge t+1+i.
- `spikes_o` and `spike_valid_o` update at edge t+N+1; `busy_o` falls at the same edge.
- The earliest next acceptance is edge t+N+2, so the minimum sweep period is N+2 cycles.
- `rd_v_o` and `rd_u_o` lag `rd_idx_i` and state writes by one cycle.
- Currents are sampled only at the acceptance edge; later changes to `currents_i` do not affect the running sweep.

## Configuration
- **`IZH_REFRACTORY_EN` defined:**
  - Each neuron carries a $clog2(REFRAC+1)-bit counter, loaded with REFRAC when the neuron spikes.
  - While the counter is nonzero, that neuron's update is skipped: v is held at C, u is unchanged, the counter decrements by 1, and no spike can occur.
  - Counters reset to 0.
- **`IZH_REFRACTORY_EN` undefined:** no counters exist, every neuron is updated on every sweep, and `REFRAC` is unused.

## Structure
- Package `izh_pkg`: FSM state enum; saturation function; default constants for 0.04/5/140 and `C`/`D`/`THRESH`, in Q.FRAC.
- Sub-module `izh_update_core`: purely combinational; inputs v, u, I; outputs the next v, next u and the spike bit. It is instantiated once in `izh_neuron_array`.

## Test plan
- **Reset check:** deassert `reset_n`; select each neuron via `rd_idx_i` → `rd_v_o`=−8320, `rd_u_o`=−1690; `spikes_o`=0; `busy_o`=0.
- **Single step, zero current:** one `step_i` with all currents 0 → `busy_o` high for N+1 cycles; `spike_valid_o` pulses at t+5 (N=4); neuron 0 then reads v=−8375, u=−1690.
- **Sustained drive:** hold neuron 1 at I=32767 for repeated steps → `spikes_o`[1] is set within 20 steps, other bits stay 0. On the spiking sweep, v1=−8320 and u1 equals un+1024, cross-checked against the reference model.
- **Overrun:** assert `step_i` at t+2 of a sweep → `overrun_o`=1 and stays 1; still exactly one `spike_valid_o`; neurons updated exactly once.
- **Reset mid-sweep:** assert `reset_n` low at t+2 → all neurons at reset values; no `spike_valid_o`; `busy_o`=0.
- **Refractory (`IZH_REFRACTORY_EN`, REFRAC=2):** after neuron 1 spikes, the next 2 sweeps leave v1=−8320 and u1 unchanged with `spikes_o`[1]=0; the third sweep updates neuron 1 again.
